// File: rtl/aibcr3_bsr_scan_ctrl.sv
// aibcr3_bsr_scan_ctrl: initiator of the AIB IO boundary-scan chain.
// One capture-shift-update pass per start; words stream in on tx and out on rx.
module aibcr3_bsr_scan_ctrl #(
    parameter int CHAIN_LEN = 96,
    parameter int DW        = 8,
    parameter int CNT_W     = 7
) (
    input  logic          jtag_clk,
    input  logic          jtag_rst,
    input  logic          start,
    input  logic          mode_en,
    input  logic          intest_en,
    input  logic [DW-1:0] tx_data,
    input  logic          tx_valid,
    output logic          tx_ready,
    output logic [DW-1:0] rx_data,
    output logic          rx_valid,
    input  logic          rx_ready,
    input  logic          jtag_rx_scan_out,
    output logic          jtag_clkdr_out,
    output logic          jtag_tx_scan_in,
    output logic          jtag_tx_scanen_in,
    output logic          jtag_mode_in,
    output logic          jtag_intest,
    output logic          jtag_rstb_en,
    output logic          busy,
    output logic          done
);
    localparam int PW = (DW > 1) ? $clog2(DW) : 1;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        CAP   = 3'd1,
        SHIFT = 3'd2,
        UPD   = 3'd3,
        DONE  = 3'd4
    } state_e;

    state_e           state_q, state_d;
    logic             ph_q, ph_d;
    logic [CNT_W-1:0] bit_q, bit_d;
    logic [PW-1:0]    pos_q, pos_d;
    logic [DW-1:0]    word_q, word_d;
    logic [DW-1:0]    rxb_q, rxb_d;
    logic [DW-1:0]    rx_data_q, rx_data_d;
    logic             have_tx_q, have_tx_d;
    logic             rx_valid_q, rx_valid_d;
    logic             scan_in_q, scan_in_d;
    logic             mode_q, mode_d;
    logic             intest_q, intest_d;

    logic in_p0;
    logic last_bit;
    logic last_pos;
    logic rx_ok;
    logic tx_fire;
    logic can_go;
    logic cur_bit;

    // ph_q is the scan clock itself, so clkdr comes straight off a flop
    assign in_p0    = (state_q == SHIFT) && !ph_q;
    assign last_bit = (bit_q == CNT_W'(CHAIN_LEN - 1));
    assign last_pos = (pos_q == PW'(DW - 1)) || last_bit;
    assign rx_ok    = !rx_valid_q || rx_ready;
    assign tx_fire  = in_p0 && (pos_q == '0) && !have_tx_q && tx_valid;
    assign can_go   = (have_tx_q || tx_valid) && rx_ok;
    assign cur_bit  = have_tx_q ? word_q[pos_q] : tx_data[0];

    always_ff @(posedge jtag_clk) begin
        if (jtag_rst) begin
            state_q    <= IDLE;
            ph_q       <= 1'b0;
            bit_q      <= '0;
            pos_q      <= '0;
            word_q     <= '0;
            rxb_q      <= '0;
            rx_data_q  <= '0;
            have_tx_q  <= 1'b0;
            rx_valid_q <= 1'b0;
            scan_in_q  <= 1'b0;
            mode_q     <= 1'b0;
            intest_q   <= 1'b0;
        end else begin
            state_q    <= state_d;
            ph_q       <= ph_d;
            bit_q      <= bit_d;
            pos_q      <= pos_d;
            word_q     <= word_d;
            rxb_q      <= rxb_d;
            rx_data_q  <= rx_data_d;
            have_tx_q  <= have_tx_d;
            rx_valid_q <= rx_valid_d;
            scan_in_q  <= scan_in_d;
            mode_q     <= mode_d;
            intest_q   <= intest_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        ph_d       = ph_q;
        bit_d      = bit_q;
        pos_d      = pos_q;
        word_d     = word_q;
        rxb_d      = rxb_q;
        rx_data_d  = rx_data_q;
        have_tx_d  = have_tx_q;
        rx_valid_d = rx_valid_q;
        scan_in_d  = scan_in_q;
        mode_d     = mode_q;
        intest_d   = intest_q;

        if (rx_valid_q && rx_ready) begin
            rx_valid_d = 1'b0;
        end

        unique case (state_q)
            IDLE: begin
                if (start) begin
                    state_d   = CAP;
                    ph_d      = 1'b0;
                    bit_d     = '0;
                    pos_d     = '0;
                    have_tx_d = 1'b0;
                    rxb_d     = '0;
                    mode_d    = mode_en;
                    intest_d  = intest_en;
                end
            end
            CAP: begin
                ph_d = !ph_q;
                if (ph_q) begin
                    state_d = SHIFT;
                end
            end
            SHIFT: begin
                if (!ph_q) begin
                    if (tx_fire) begin
                        word_d    = tx_data;
                        have_tx_d = 1'b1;
                    end
                    // a tx word may be taken while rx is still blocking
                    if (can_go) begin
                        ph_d         = 1'b1;
                        scan_in_d    = cur_bit;
                        rxb_d[pos_q] = jtag_rx_scan_out;
                    end
                end else begin
                    ph_d = 1'b0;
                    if (last_pos) begin
                        rx_valid_d = 1'b1;
                        rx_data_d  = rxb_q;
                        rxb_d      = '0;
                        have_tx_d  = 1'b0;
                        pos_d      = '0;
                    end else begin
                        pos_d = pos_q + 1'b1;
                    end
                    if (last_bit) begin
                        state_d = UPD;
                    end else begin
                        bit_d = bit_q + 1'b1;
                    end
                end
            end
            UPD: begin
                if (!ph_q) begin
                    if (rx_ok) begin
                        ph_d = 1'b1;
                    end
                end else begin
                    ph_d    = 1'b0;
                    state_d = DONE;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
                ph_d    = 1'b0;
            end
        endcase
    end

    always_comb begin
        tx_ready          = tx_fire;
        rx_valid          = rx_valid_q;
        rx_data           = rx_data_q;
        jtag_clkdr_out    = ph_q;
        jtag_tx_scan_in   = in_p0 ? cur_bit : scan_in_q;
        jtag_tx_scanen_in = (state_q == SHIFT);
        jtag_mode_in      = mode_q;
        jtag_intest       = intest_q;
        busy              = (state_q != IDLE);
        jtag_rstb_en      = (state_q != IDLE);
        done              = (state_q == DONE);
    end

endmodule

// File: tb/tb_aibcr3_bsr_scan_ctrl.sv
// Bench for aibcr3_bsr_scan_ctrl: two chain lengths, directed table plus
// random handshakes checked against a word-level chain model.
module tb_aibcr3_bsr_scan_ctrl;
  localparam int DW = 8;

  typedef struct {
    int          u;
    logic [15:0] pre;
    logic [7:0]  w0;
    logic [7:0]  w1;
    int          gap;
    int          hold;
    bit          m;
    bit          it;
    int          lat;
  } vec_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst;

  logic          start[2], mode_en[2], intest_en[2];
  logic          tx_valid[2], tx_ready[2], rx_valid[2], rx_ready[2];
  logic [DW-1:0] tx_data[2], rx_data[2];
  logic          scan_out[2], clkdr[2], scan_in[2], scanen[2];
  logic          jmode[2], jintest[2], rstb_en[2], busy[2], done[2];
  logic [15:0]   chain[2];

  int ntot = 0;
  int npass = 0;

  assign scan_out[0] = chain[0][0];
  assign scan_out[1] = chain[1][0];

  aibcr3_bsr_scan_ctrl #(.CHAIN_LEN(16), .DW(DW), .CNT_W(5)) u0 (
    .jtag_clk(clk), .jtag_rst(rst), .start(start[0]),
    .mode_en(mode_en[0]), .intest_en(intest_en[0]),
    .tx_data(tx_data[0]), .tx_valid(tx_valid[0]), .tx_ready(tx_ready[0]),
    .rx_data(rx_data[0]), .rx_valid(rx_valid[0]), .rx_ready(rx_ready[0]),
    .jtag_rx_scan_out(scan_out[0]), .jtag_clkdr_out(clkdr[0]),
    .jtag_tx_scan_in(scan_in[0]), .jtag_tx_scanen_in(scanen[0]),
    .jtag_mode_in(jmode[0]), .jtag_intest(jintest[0]),
    .jtag_rstb_en(rstb_en[0]), .busy(busy[0]), .done(done[0]));

  aibcr3_bsr_scan_ctrl #(.CHAIN_LEN(13), .DW(DW), .CNT_W(4)) u1 (
    .jtag_clk(clk), .jtag_rst(rst), .start(start[1]),
    .mode_en(mode_en[1]), .intest_en(intest_en[1]),
    .tx_data(tx_data[1]), .tx_valid(tx_valid[1]), .tx_ready(tx_ready[1]),
    .rx_data(rx_data[1]), .rx_valid(rx_valid[1]), .rx_ready(rx_ready[1]),
    .jtag_rx_scan_out(scan_out[1]), .jtag_clkdr_out(clkdr[1]),
    .jtag_tx_scan_in(scan_in[1]), .jtag_tx_scanen_in(scanen[1]),
    .jtag_mode_in(jmode[1]), .jtag_intest(jintest[1]),
    .jtag_rstb_en(rstb_en[1]), .busy(busy[1]), .done(done[1]));

  function automatic int cl(input int u);
    return (u != 0) ? 13 : 16;
  endfunction

  function automatic void chk(input string name,
                              input logic [31:0] act,
                              input logic [31:0] exp);
    ntot++;
    if (act === exp) npass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endfunction

  function automatic logic [31:0] outs(input int u);
    return {tx_ready[u], rx_valid[u], rx_data[u], clkdr[u], scan_in[u],
            scanen[u], jmode[u], jintest[u], rstb_en[u], busy[u], done[u]};
  endfunction

  task automatic run_pass(input int u, input logic [15:0] pre,
                          input logic [7:0] w0, input logic [7:0] w1,
                          input int gap, input int hold, input bit rnd,
                          input bit m, input bit it, input int exp_lat);
    int cyc = 0;
    int txc = 0;
    int pulses = 0;
    int spulses = 0;
    int gapcnt = 0;
    int hcnt = 0;
    int viol = 0;
    int nw = (cl(u) + DW - 1) / DW;
    bit holding = 1'b0;
    logic prev_clk;
    logic [7:0] held = '0;
    logic [7:0] words[2];
    logic [7:0] rxq[$];
    logic [15:0] mask = 16'((32'd1 << cl(u)) - 1);
    logic [15:0] expw;
    words[0] = w0;
    words[1] = w1;
    chain[u] = pre & mask;
    mode_en[u] = m;
    intest_en[u] = it;
    start[u] = 1'b1;
    @(posedge clk); #1;
    start[u] = 1'b0;
    cyc = 1;
    prev_clk = clkdr[u];
    chk("busy_on", {31'd0, busy[u]}, 32'd1);
    while (done[u] !== 1'b1 && cyc < 400) begin
      tx_data[u] = words[(txc < nw) ? txc : 0];
      if (rnd) tx_valid[u] = ($urandom % 4) != 0;
      else if (txc == 1 && gap > 0) begin
        tx_valid[u] = (gapcnt >= gap);
        if (spulses >= DW && !clkdr[u] && gapcnt < gap) gapcnt++;
      end else tx_valid[u] = 1'b1;
      if (rnd) rx_ready[u] = ($urandom % 3) != 0;
      else if (hold > 0 && rxq.size() == 0 && rx_valid[u] && hcnt < hold) begin
        rx_ready[u] = 1'b0;
        hcnt++;
      end else rx_ready[u] = 1'b1;
      start[u] = (cyc == 10);
      mode_en[u] = (cyc == 10) ? !m : m;
      intest_en[u] = (cyc == 10) ? !it : it;
      if (busy[u] !== 1'b1 || rstb_en[u] !== 1'b1) viol++;
      @(negedge clk);
      if (tx_valid[u] && tx_ready[u]) txc++;
      if (rx_valid[u] && rx_ready[u]) begin
        rxq.push_back(rx_data[u]);
        holding = 1'b0;
      end else if (rx_valid[u]) begin
        if (holding && rx_data[u] !== held) viol++;
        holding = 1'b1;
        held = rx_data[u];
      end else holding = 1'b0;
      @(posedge clk); #1;
      cyc++;
      if (holding && clkdr[u] !== prev_clk) viol++;
      if (clkdr[u] && !prev_clk) begin
        pulses++;
        if (scanen[u]) begin
          spulses++;
          chain[u] = ((chain[u] >> 1) | (16'(scan_in[u]) << (cl(u) - 1))) & mask;
        end
      end
      prev_clk = clkdr[u];
    end
    chk("done_seen", {31'd0, done[u]}, 32'd1);
    start[u] = 1'b1;
    mode_en[u] = !m;
    intest_en[u] = !it;
    tx_valid[u] = 1'b0;
    rx_ready[u] = 1'b1;
    @(posedge clk); #1;
    start[u] = 1'b0;
    chk("busy_after_done", {31'd0, busy[u]}, 32'd0);
    chk("done_pulse", {31'd0, done[u]}, 32'd0);
    chk("mode_held", {30'd0, jmode[u], jintest[u]}, {30'd0, m, it});
    if (exp_lat > 0) chk("latency", cyc, exp_lat);
    else chk("latency_min", {31'd0, cyc >= 2 * cl(u) + 5}, 32'd1);
    chk("tx_words", txc, nw);
    chk("rx_words", rxq.size(), nw);
    for (int k = 0; k < nw; k++) begin
      expw = (pre & mask) >> (8 * k);
      chk("rx_data", (k < rxq.size()) ? {24'd0, rxq[k]} : 32'hdead,
          {24'd0, expw[7:0]});
    end
    chk("chain_final", {16'd0, chain[u]}, {16'd0, {w1, w0} & mask});
    chk("clkdr_pulses", pulses, cl(u) + 2);
    chk("stall_rules", viol, 0);
  endtask

  task automatic reset_mid_pass();
    int sp = 0;
    int rises = 0;
    logic prev_clk;
    chain[0] = 16'hBEEF;
    mode_en[0] = 1'b1;
    intest_en[0] = 1'b1;
    start[0] = 1'b1;
    @(posedge clk); #1;
    start[0] = 1'b0;
    prev_clk = clkdr[0];
    for (int c = 0; c < 200 && sp < 7; c++) begin
      tx_valid[0] = 1'b1;
      tx_data[0] = 8'h5A;
      rx_ready[0] = 1'b1;
      @(posedge clk); #1;
      if (clkdr[0] && !prev_clk && scanen[0]) sp++;
      prev_clk = clkdr[0];
    end
    chk("reached_bit7", sp, 7);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    chk("rst_mid_outs", outs(0), 32'd0);
    prev_clk = clkdr[0];
    for (int c = 0; c < 4; c++) begin
      @(posedge clk); #1;
      if (clkdr[0] !== prev_clk) rises++;
      prev_clk = clkdr[0];
    end
    chk("rst_no_clkdr", rises, 0);
    chk("rst_idle", {31'd0, busy[0]}, 32'd0);
    tx_valid[0] = 1'b0;
  endtask

  initial begin
    vec_t vt[5];
    vt[0] = '{0, 16'hBEEF, 8'hA5, 8'h3C, 0, 0, 1'b1, 1'b0, 37};
    vt[1] = '{0, 16'hBEEF, 8'hA5, 8'h3C, 5, 0, 1'b1, 1'b1, 42};
    vt[2] = '{0, 16'hBEEF, 8'hA5, 8'h3C, 0, 10, 1'b0, 1'b1, 47};
    vt[3] = '{1, 16'h1FFF, 8'hA5, 8'h3C, 0, 0, 1'b0, 1'b0, 31};
    vt[4] = '{0, 16'h1234, 8'hFF, 8'h00, 5, 10, 1'b1, 1'b0, 47};
    for (int u = 0; u < 2; u++) begin
      start[u] = 1'b0;
      mode_en[u] = 1'b0;
      intest_en[u] = 1'b0;
      tx_valid[u] = 1'b0;
      tx_data[u] = '0;
      rx_ready[u] = 1'b0;
      chain[u] = '0;
    end
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_outs_u0", outs(0), 32'd0);
    chk("reset_outs_u1", outs(1), 32'd0);
    rst = 1'b0;
    for (int i = 0; i < 5; i++)
      run_pass(vt[i].u, vt[i].pre, vt[i].w0, vt[i].w1, vt[i].gap,
               vt[i].hold, 1'b0, vt[i].m, vt[i].it, vt[i].lat);
    reset_mid_pass();
    run_pass(vt[0].u, vt[0].pre, vt[0].w0, vt[0].w1, 0, 0, 1'b0,
             1'b0, 1'b1, 37);
    for (int i = 0; i < 8; i++)
      run_pass(int'($urandom % 2), 16'($urandom), 8'($urandom),
               8'($urandom), 0, 0, 1'b1, 1'($urandom), 1'($urandom), 0);
    $display("%0d/%0d checks passed", npass, ntot);
    $finish;
  end
endmodule
